// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier: FSM state encoding
// and the width of the step counter derived from the operand width.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SHIFT,
    DONE
  } state_t;

  // Step counter must index 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/shift_reg_n.sv
// Generic right-shift register with synchronous clear, parallel load and
// serial in/out; clear wins over load, load wins over shift.
module shift_reg_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

  assign sout = q[0];

endmodule

// File: rtl/mult_shift_unit.sv
// Shift-add multiplier on the {X, A, B} register chain with its own control
// FSM; the 2*WIDTH-bit product is read from {A, B} while Done is high.
module mult_shift_unit
  import mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Load_B,
  input  logic             Clear_A,
  input  logic [WIDTH-1:0] Data_In,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    cnt;

  logic             idle_load;
  logic             idle_clear;
  logic             go;
  logic             add_en;
  logic             is_shift;
  logic             last_step;
  logic             x_in;
  logic             a_sout;
  logic             b_sout;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   sum;

  assign idle_load  = (state == IDLE) && Load_B;
  assign idle_clear = (state == IDLE) && !Load_B && Clear_A;
  assign go         = (state == IDLE) && Start && !Load_B && !Clear_A;
  // b_sout is B[0], the multiplier bit examined on this step.
  assign add_en     = (state == ADD) && b_sout;
  assign is_shift   = (state == SHIFT);
  assign last_step  = (cnt == LAST);

  // Signed mode: the MSB of the multiplier has negative weight, so the last
  // partial product is subtracted instead of added.
  assign a_ext = (SIGNED != 0) ? {A[WIDTH-1], A} : {1'b0, A};
  assign m_ext = (SIGNED != 0) ? {m[WIDTH-1], m} : {1'b0, m};
  assign sum   = ((SIGNED != 0) && last_step) ? (a_ext - m_ext) : (a_ext + m_ext);
  assign x_in  = (SIGNED != 0) ? X : 1'b0;

  shift_reg_n #(.WIDTH(WIDTH)) u_reg_a (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (idle_load || idle_clear),
    .load  (add_en),
    .shift (is_shift),
    .sin   (X),
    .d     (sum[WIDTH-1:0]),
    .q     (A),
    .sout  (a_sout)
  );

  shift_reg_n #(.WIDTH(WIDTH)) u_reg_b (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (1'b0),
    .load  (idle_load),
    .shift (is_shift),
    .sin   (a_sout),
    .d     (Data_In),
    .q     (B),
    .sout  (b_sout)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      X <= 1'b0;
      m <= '0;
    end else begin
      if (idle_load || idle_clear) begin
        X <= 1'b0;
      end else if (add_en) begin
        X <= sum[WIDTH];
      end else if (is_shift) begin
        X <= x_in;
      end
      // Multiplicand is captured once so switch changes cannot disturb a run.
      if (go) begin
        m <= Data_In;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            cnt   <= '0;
            state <= ADD;
            Busy  <= 1'b1;
          end
        end
        ADD: begin
          state <= SHIFT;
        end
        SHIFT: begin
          if (last_step) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ADD;
          end
        end
        DONE: begin
          // Start must drop before another multiply can be requested.
          if (!Start) begin
            state <= IDLE;
            Done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_shift_unit.sv
// Directed bench for mult_shift_unit: 8-bit signed, 8-bit unsigned and 4-bit
// signed instances, hand-computed products and control corner cases.
module tb_mult_shift_unit;

  logic clk;
  logic rst_n;

  logic       s8_start, s8_lb, s8_ca, s8_x, s8_busy, s8_done;
  logic [7:0] s8_din, s8_a, s8_b;
  logic       u8_start, u8_lb, u8_ca, u8_x, u8_busy, u8_done;
  logic [7:0] u8_din, u8_a, u8_b;
  logic       s4_start, s4_lb, s4_ca, s4_x, s4_busy, s4_done;
  logic [3:0] s4_din, s4_a, s4_b;

  int n_checks;
  int n_fail;
  int cyc;

  mult_shift_unit #(.WIDTH(8), .SIGNED(1)) dut_s8 (
    .Clk(clk), .Reset_n(rst_n), .Start(s8_start), .Load_B(s8_lb), .Clear_A(s8_ca),
    .Data_In(s8_din), .A(s8_a), .B(s8_b), .X(s8_x), .Busy(s8_busy), .Done(s8_done)
  );

  mult_shift_unit #(.WIDTH(8), .SIGNED(0)) dut_u8 (
    .Clk(clk), .Reset_n(rst_n), .Start(u8_start), .Load_B(u8_lb), .Clear_A(u8_ca),
    .Data_In(u8_din), .A(u8_a), .B(u8_b), .X(u8_x), .Busy(u8_busy), .Done(u8_done)
  );

  mult_shift_unit #(.WIDTH(4), .SIGNED(1)) dut_s4 (
    .Clk(clk), .Reset_n(rst_n), .Start(s4_start), .Load_B(s4_lb), .Clear_A(s4_ca),
    .Data_In(s4_din), .A(s4_a), .B(s4_b), .X(s4_x), .Busy(s4_busy), .Done(s4_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic s8_loadb(input logic [7:0] v);
    s8_lb  = 1'b1;
    s8_din = v;
    @(negedge clk);
    s8_lb  = 1'b0;
  endtask

  // Raises Start with the multiplicand and counts falling edges until Done.
  task automatic s8_run(input logic [7:0] mcand, output int n);
    s8_din   = mcand;
    s8_start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s8_done && n < 60);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    {s8_start, s8_lb, s8_ca} = 3'b000; s8_din = 8'h00;
    {u8_start, u8_lb, u8_ca} = 3'b000; u8_din = 8'h00;
    {s4_start, s4_lb, s4_ca} = 3'b000; s4_din = 4'h0;

    repeat (2) @(negedge clk);
    check("reset_a", s8_a, 8'h00);
    check("reset_b", s8_b, 8'h00);
    check("reset_x", s8_x, 1'b0);
    check("reset_busy", s8_busy, 1'b0);
    check("reset_done", s8_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // -3 x 7 = -21
    s8_loadb(8'hFD);
    check("load_b", s8_b, 8'hFD);
    s8_run(8'h07, cyc);
    check("m3x7_latency", cyc, 17);
    check("m3x7_a", s8_a, 8'hFF);
    check("m3x7_b", s8_b, 8'hEB);
    check("m3x7_x", s8_x, 1'b1);
    check("m3x7_busy", s8_busy, 1'b0);
    s8_start = 1'b0;
    @(negedge clk);
    check("idle_done", s8_done, 1'b0);

    // Clear_A beats Start and leaves B alone
    s8_ca = 1'b1; s8_start = 1'b1;
    @(negedge clk);
    check("clear_a", s8_a, 8'h00);
    check("clear_x", s8_x, 1'b0);
    check("clear_keeps_b", s8_b, 8'hEB);
    check("clear_blocks_start", s8_busy, 1'b0);
    s8_ca = 1'b0; s8_start = 1'b0;
    @(negedge clk);

    // -128 x -128 = 16384
    s8_loadb(8'h80);
    s8_run(8'h80, cyc);
    check("m128_a", s8_a, 8'h40);
    check("m128_b", s8_b, 8'h00);
    check("m128_x", s8_x, 1'b0);
    s8_start = 1'b0;
    @(negedge clk);

    // Load_B with Start: load only, then start with the new B (3 x 5)
    s8_lb = 1'b1; s8_din = 8'h03; s8_start = 1'b1;
    @(negedge clk);
    check("lb_start_b", s8_b, 8'h03);
    check("lb_start_busy", s8_busy, 1'b0);
    s8_lb = 1'b0;
    s8_run(8'h05, cyc);
    check("m3x5_latency", cyc, 17);
    check("m3x5_a", s8_a, 8'h00);
    check("m3x5_b", s8_b, 8'h0F);
    check("m3x5_x", s8_x, 1'b0);
    s8_start = 1'b0;
    @(negedge clk);

    // Switch changes and Load_B during a run are ignored; Start held after Done
    s8_loadb(8'hFD);
    s8_din = 8'h07; s8_start = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_busy", s8_busy, 1'b1);
    s8_din = 8'h55; s8_lb = 1'b1;
    @(negedge clk);
    s8_lb = 1'b0;
    cyc = 4;
    do begin
      @(negedge clk);
      cyc++;
    end while (!s8_done && cyc < 60);
    check("iso_latency", cyc, 17);
    check("iso_a", s8_a, 8'hFF);
    check("iso_b", s8_b, 8'hEB);
    check("iso_x", s8_x, 1'b1);
    repeat (4) @(negedge clk);
    check("hold_done", s8_done, 1'b1);
    check("hold_busy", s8_busy, 1'b0);
    check("hold_a", s8_a, 8'hFF);
    s8_start = 1'b0;
    @(negedge clk);
    check("release_done", s8_done, 1'b0);
    check("release_busy", s8_busy, 1'b0);

    // Asynchronous reset in the middle of a multiply
    s8_loadb(8'hFD);
    s8_din = 8'h07; s8_start = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a", s8_a, 8'h00);
    check("arst_b", s8_b, 8'h00);
    check("arst_x", s8_x, 1'b0);
    check("arst_busy", s8_busy, 1'b0);
    check("arst_done", s8_done, 1'b0);
    s8_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // 6 x -5 = -30
    s8_loadb(8'h06);
    s8_run(8'hFB, cyc);
    check("m6x5_latency", cyc, 17);
    check("m6x5_a", s8_a, 8'hFF);
    check("m6x5_b", s8_b, 8'hE2);
    check("m6x5_x", s8_x, 1'b1);
    s8_start = 1'b0;

    // Unsigned 255 x 255 = 65025
    u8_lb = 1'b1; u8_din = 8'hFF;
    @(negedge clk);
    u8_lb = 1'b0; u8_start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!u8_done && cyc < 60);
    check("u255_latency", cyc, 17);
    check("u255_a", u8_a, 8'hFE);
    check("u255_b", u8_b, 8'h01);
    check("u255_x", u8_x, 1'b0);
    u8_start = 1'b0;

    // 4-bit signed 7 x -7 = -49
    s4_lb = 1'b1; s4_din = 4'h7;
    @(negedge clk);
    s4_lb = 1'b0; s4_din = 4'h9; s4_start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!s4_done && cyc < 60);
    check("w4_latency", cyc, 9);
    check("w4_a", s4_a, 4'hC);
    check("w4_b", s4_b, 4'hF);
    check("w4_x", s4_x, 1'b1);
    s4_start = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
